// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control path: hazard FSM states
// and the opcode constants used by decode.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hz_state_e;

    localparam logic [5:0] NOP_OPCODE = 6'b111111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, ID-stage
// redirect flushes, data-memory freeze with timeout, and stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_en,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e        state_q;
    logic [WC_W-1:0]  wait_cnt_q;
    logic             timeout_err_q;

    logic freeze, load_use, redirect;

    assign freeze   = mem_req & ~mem_ready;
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign redirect = branch_taken | jump;

    // Priority: halt (reset/error/freeze) > load-use bubble > redirect flush.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b1;
        if (rst || (state_q == ST_ERR) || freeze) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (redirect) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (freeze) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_cnt_q <= WC_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!freeze) begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
                        state_q       <= ST_ERR;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                ST_ERR: begin
                    timeout_err_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    assign timeout_err = timeout_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~pc_en),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ifid_flush),
        .q   (flush_cnt)
    );

endmodule
